// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if
//   Bundles the control and output signals of the clock divider bank so that
//   the controller side (master) and the divider bank (slave) share one port.
//
//   Signals:
//     clear     master->slave  synchronous restart of all channel phases
//     enable    master->slave  per-channel run enable
//     load      master->slave  one-cycle strobe: write load_div to load_sel
//     load_sel  master->slave  target channel of load
//     load_div  master->slave  new divisor value
//     div_out   slave->master  per-channel square wave, period 2*(div+1) clk
//     tick      slave->master  per-channel 1-cycle pulse at terminal count
//
//   Handshake: load is a fire-and-forget strobe with no ready. The bank
//   accepts every load in the cycle it is high. A load_sel that names no
//   channel is dropped. Nothing stalls, so there is no back-pressure.
interface clk_div_bank_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 25,
  parameter int SEL_W    = 2
);
  logic                clear;
  logic [CHANNELS-1:0] enable;
  logic                load;
  logic [SEL_W-1:0]    load_sel;
  logic [CNT_W-1:0]    load_div;
  logic [CHANNELS-1:0] div_out;
  logic [CHANNELS-1:0] tick;

  modport master (
    output clear, enable, load, load_sel, load_div,
    input  div_out, tick
  );

  modport slave (
    input  clear, enable, load, load_sel, load_div,
    output div_out, tick
  );
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of CHANNELS independent programmable clock dividers running from one
//   clock. Each channel produces a square-wave enable clock (div_out, period
//   2*(div+1) clk) and a one-cycle tick at terminal count. A new divisor can be
//   loaded at runtime. It is staged in a shadow register and only committed at
//   terminal count, or while the channel is disabled, so a running half-period
//   is never cut short or stretched.
//
//   Ports:
//     clk    in  system clock, all logic on posedge
//     rst_n  in  asynchronous reset, active low
//     bus    clk_div_bank_if.slave (clear, enable, load, load_sel, load_div in;
//            div_out, tick out)
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 25,
  parameter int SEL_W       = 2,
  parameter int DEFAULT_DIV = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  clk_div_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0]    cnt_q     [CHANNELS];
  logic [CNT_W-1:0]    cnt_d     [CHANNELS];
  logic [CNT_W-1:0]    act_div_q [CHANNELS];
  logic [CNT_W-1:0]    act_div_d [CHANNELS];
  logic [CNT_W-1:0]    shd_div_q [CHANNELS];
  logic [CNT_W-1:0]    shd_div_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] div_out_q, div_out_d;
  logic [CHANNELS-1:0] tick_q, tick_d;

  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] load_hit;

  // A load_sel of CHANNELS or above matches no index, so an illegal load
  // changes nothing without needing a separate range check.
  always_comb begin
    tc       = '0;
    load_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      tc[i]       = bus.enable[i] && (cnt_q[i] == act_div_q[i]);
      load_hit[i] = bus.load && (bus.load_sel == SEL_W'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]     = cnt_q[i];
      act_div_d[i] = act_div_q[i];
      shd_div_d[i] = shd_div_q[i];
      pend_d[i]    = pend_q[i];
      div_out_d[i] = div_out_q[i];
      tick_d[i]    = 1'b0;

      if (bus.clear) begin
        // Restart the phase but keep every divisor and any pending load.
        cnt_d[i]     = '0;
        div_out_d[i] = 1'b0;
      end else if (!bus.enable[i]) begin
        // A stopped channel has no phase to protect: commit at once.
        if (pend_q[i]) begin
          act_div_d[i] = shd_div_q[i];
          pend_d[i]    = 1'b0;
        end
      end else if (tc[i]) begin
        cnt_d[i]     = '0;
        div_out_d[i] = ~div_out_q[i];
        tick_d[i]    = 1'b1;
        if (pend_q[i]) begin
          act_div_d[i] = shd_div_q[i];
          pend_d[i]    = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      // A load landing on the TC cycle goes straight to the active divisor;
      // the older shadow value is superseded and nothing stays pending.
      if (load_hit[i]) begin
        shd_div_d[i] = bus.load_div;
        if (!bus.clear && tc[i]) begin
          act_div_d[i] = bus.load_div;
          pend_d[i]    = 1'b0;
        end else begin
          pend_d[i]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i]     <= '0;
        act_div_q[i] <= DEF_DIV;
        shd_div_q[i] <= DEF_DIV;
      end
      pend_q    <= '0;
      div_out_q <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      act_div_q <= act_div_d;
      shd_div_q <= shd_div_d;
      pend_q    <= pend_d;
      div_out_q <= div_out_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.div_out = div_out_q;
  assign bus.tick    = tick_q;

endmodule
